direct_residual_calc: RTL and testbench

- Stage directly downstream of LineBufCtrl in the direct (photometric) odometry path.
- Consumes per-pixel correspondences: frame-0 intensity/depth plus the frame-1 5-point neighbourhood fetched from the line buffer.
- Produces per-correspondence photometric residual and frame-1 intensity gradients for the direct Jacobian stage.
- Accumulates per-frame valid-correspondence count and sum of squared residuals (SSE), reported once at frame end.

---
 rtl/direct_residual_calc_pkg.sv | 18 +
 rtl/direct_residual_calc_if.sv | 25 ++
 rtl/direct_residual_calc_res_frame_acc.sv | 90 +++++++++
 rtl/direct_residual_calc.sv | 95 +++++++++
 tb/tb_direct_residual_calc.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/direct_residual_calc_pkg.sv
// rtl/direct_residual_calc_pkg.sv - shared widths, latency and FSM type for the direct residual stage
package direct_residual_calc_pkg;

    localparam int CORR_CNT_BW  = 19;
    localparam int SSE_BW       = 35;
    localparam int RES_PIPE_LAT = 2;

    // Drain length covers every correspondence still in the datapath when frame_end arrives
    localparam logic [1:0] DRAIN_LOAD = 2'(RES_PIPE_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } res_state_t;

endpackage

// File: rtl/direct_residual_calc_if.sv
// rtl/direct_residual_calc_if.sv - per-pixel correspondence bundle from the line buffer
interface direct_residual_calc_if #(
    parameter int DATA_BW  = 8,
    parameter int DEPTH_BW = 16
);
    logic                i_valid;
    logic [DATA_BW-1:0]  i_data0;
    logic [DEPTH_BW-1:0] i_depth0;
    logic [DATA_BW-1:0]  i_data1_c;
    logic [DATA_BW-1:0]  i_data1_l;
    logic [DATA_BW-1:0]  i_data1_r;
    logic [DATA_BW-1:0]  i_data1_u;
    logic [DATA_BW-1:0]  i_data1_d;
    logic [DEPTH_BW-1:0] i_depth1;

    modport master (
        output i_valid, i_data0, i_depth0,
        output i_data1_c, i_data1_l, i_data1_r, i_data1_u, i_data1_d, i_depth1
    );

    modport slave (
        input i_valid, i_data0, i_depth0,
        input i_data1_c, i_data1_l, i_data1_r, i_data1_u, i_data1_d, i_depth1
    );
endinterface

// File: rtl/direct_residual_calc_res_frame_acc.sv
// rtl/direct_residual_calc_res_frame_acc.sv - frame FSM, drain counter and saturating count/SSE accumulators
module res_frame_acc
    import direct_residual_calc_pkg::*;
#(
    parameter int ACC_CNT_BW = 19,
    parameter int ACC_SSE_BW = 35,
    parameter int SQ_BW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  acc_valid,
    input  logic [SQ_BW-1:0]      acc_sq,
    output logic                  stat_valid,
    output logic [ACC_CNT_BW-1:0] corr_cnt,
    output logic [ACC_SSE_BW-1:0] sse
);

    res_state_t            state;
    logic [1:0]            drain;
    logic [ACC_CNT_BW-1:0] cnt_acc;
    logic [ACC_SSE_BW-1:0] sse_acc;
    logic [ACC_SSE_BW:0]   sse_sum;

    // One extra bit catches the carry so the SSE can clamp instead of wrapping
    assign sse_sum = {1'b0, sse_acc} + {{(ACC_SSE_BW + 1 - SQ_BW){1'b0}}, acc_sq};

    // Frame sequencing: accumulate while ACTIVE/FLUSH, drain the pipeline, publish once in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain      <= 2'd0;
            cnt_acc    <= '0;
            sse_acc    <= '0;
            stat_valid <= 1'b0;
            corr_cnt   <= '0;
            sse        <= '0;
        end else begin
            stat_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= ACTIVE;
                        cnt_acc <= '0;
                        sse_acc <= '0;
                    end
                end
                ACTIVE, FLUSH: begin
                    if (frame_start) begin
                        // Abort: restart the frame without publishing anything
                        state   <= ACTIVE;
                        cnt_acc <= '0;
                        sse_acc <= '0;
                    end else begin
                        if (acc_valid) begin
                            cnt_acc <= (&cnt_acc) ? cnt_acc : cnt_acc + 1'b1;
                            sse_acc <= sse_sum[ACC_SSE_BW] ? '1 : sse_sum[ACC_SSE_BW-1:0];
                        end
                        if (state == ACTIVE) begin
                            if (frame_end) begin
                                state <= FLUSH;
                                drain <= DRAIN_LOAD;
                            end
                        end else begin
                            drain <= drain - 2'd1;
                            if (drain == 2'd1) begin
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    stat_valid <= 1'b1;
                    corr_cnt   <= cnt_acc;
                    sse        <= sse_acc;
                    if (frame_start) begin
                        state   <= ACTIVE;
                        cnt_acc <= '0;
                        sse_acc <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/direct_residual_calc.sv
// rtl/direct_residual_calc.sv - photometric residual, frame-1 gradients and per-frame residual statistics
module direct_residual_calc #(
    parameter int DATA_BW  = 8,
    parameter int DEPTH_BW = 16,
    parameter int CNT_BW   = direct_residual_calc_pkg::CORR_CNT_BW,
    parameter int SSE_BW   = direct_residual_calc_pkg::SSE_BW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    direct_residual_calc_if.slave     corr,
    input  logic                      i_frame_start,
    input  logic                      i_frame_end,
    input  logic [DEPTH_BW-1:0]       r_min_depth,
    input  logic [DEPTH_BW-1:0]       r_max_depth,
    input  logic [DATA_BW-1:0]        r_max_res,
    output logic                      o_valid,
    output logic signed [DATA_BW:0]   o_residual,
    output logic signed [DATA_BW:0]   o_grad_x,
    output logic signed [DATA_BW:0]   o_grad_y,
    output logic                      o_stat_valid,
    output logic [CNT_BW-1:0]         o_corr_cnt,
    output logic [SSE_BW-1:0]         o_sse
);

    localparam int SQ_BW = 2 * DATA_BW;

    logic signed [DATA_BW:0] s1_res;
    logic signed [DATA_BW:0] s1_gx;
    logic signed [DATA_BW:0] s1_gy;
    logic                    s1_accept;
    logic                    depth_ok;
    logic [DATA_BW:0]        s1_abs;
    logic [SQ_BW-1:0]        abs_ext;
    logic                    s2_take;
    logic [SQ_BW-1:0]        s2_sq;

    assign depth_ok = (corr.i_depth0 >= r_min_depth) && (corr.i_depth0 <= r_max_depth)
                      && (corr.i_depth1 != '0);

    // Stage 1: nine-bit differences of zero-extended intensities plus the depth gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_res    <= '0;
            s1_gx     <= '0;
            s1_gy     <= '0;
            s1_accept <= 1'b0;
        end else begin
            s1_res    <= {1'b0, corr.i_data1_c} - {1'b0, corr.i_data0};
            s1_gx     <= {1'b0, corr.i_data1_r} - {1'b0, corr.i_data1_l};
            s1_gy     <= {1'b0, corr.i_data1_d} - {1'b0, corr.i_data1_u};
            s1_accept <= corr.i_valid && depth_ok;
        end
    end

    // Magnitude never exceeds 2^DATA_BW-1, so the square fits in SQ_BW bits
    assign s1_abs  = s1_res[DATA_BW] ? (~s1_res + 1'b1) : s1_res;
    assign abs_ext = {{DATA_BW{1'b0}}, s1_abs[DATA_BW-1:0]};
    assign s2_take = s1_accept && (s1_abs <= {1'b0, r_max_res});

    // Stage 2: residual limit, hold last accepted result, square for the SSE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_residual <= '0;
            o_grad_x   <= '0;
            o_grad_y   <= '0;
            s2_sq      <= '0;
        end else begin
            o_valid <= s2_take;
            if (s2_take) begin
                o_residual <= s1_res;
                o_grad_x   <= s1_gx;
                o_grad_y   <= s1_gy;
                s2_sq      <= abs_ext * abs_ext;
            end
        end
    end

    res_frame_acc #(
        .ACC_CNT_BW (CNT_BW),
        .ACC_SSE_BW (SSE_BW),
        .SQ_BW      (SQ_BW)
    ) u_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (i_frame_start),
        .frame_end   (i_frame_end),
        .acc_valid   (o_valid),
        .acc_sq      (s2_sq),
        .stat_valid  (o_stat_valid),
        .corr_cnt    (o_corr_cnt),
        .sse         (o_sse)
    );

endmodule

// File: tb/tb_direct_residual_calc.sv
// tb/tb_direct_residual_calc.sv - directed self-checking bench for direct_residual_calc
module tb_direct_residual_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_frame_start;
    logic        i_frame_end;
    logic [15:0] r_min_depth;
    logic [15:0] r_max_depth;
    logic [7:0]  r_max_res;

    logic               o_valid;
    logic signed [8:0]  o_residual;
    logic signed [8:0]  o_grad_x;
    logic signed [8:0]  o_grad_y;
    logic               o_stat_valid;
    logic [18:0]        o_corr_cnt;
    logic [34:0]        o_sse;

    logic               s_valid;
    logic signed [8:0]  s_residual;
    logic signed [8:0]  s_grad_x;
    logic signed [8:0]  s_grad_y;
    logic               s_stat_valid;
    logic [2:0]         s_corr_cnt;
    logic [16:0]        s_sse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    direct_residual_calc_if #(.DATA_BW(8), .DEPTH_BW(16)) corr_if ();

    direct_residual_calc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .corr          (corr_if),
        .i_frame_start (i_frame_start),
        .i_frame_end   (i_frame_end),
        .r_min_depth   (r_min_depth),
        .r_max_depth   (r_max_depth),
        .r_max_res     (r_max_res),
        .o_valid       (o_valid),
        .o_residual    (o_residual),
        .o_grad_x      (o_grad_x),
        .o_grad_y      (o_grad_y),
        .o_stat_valid  (o_stat_valid),
        .o_corr_cnt    (o_corr_cnt),
        .o_sse         (o_sse)
    );

    // Narrow accumulators so saturation is reachable in a few cycles
    direct_residual_calc #(.CNT_BW(3), .SSE_BW(17)) dut_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .corr          (corr_if),
        .i_frame_start (i_frame_start),
        .i_frame_end   (i_frame_end),
        .r_min_depth   (r_min_depth),
        .r_max_depth   (r_max_depth),
        .r_max_res     (r_max_res),
        .o_valid       (s_valid),
        .o_residual    (s_residual),
        .o_grad_x      (s_grad_x),
        .o_grad_y      (s_grad_y),
        .o_stat_valid  (s_stat_valid),
        .o_corr_cnt    (s_corr_cnt),
        .o_sse         (s_sse)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d0, input int c, input int l, input int r,
                         input int u, input int d, input int dp0, input int dp1);
        corr_if.i_valid   = 1'b1;
        corr_if.i_data0   = 8'(d0);
        corr_if.i_data1_c = 8'(c);
        corr_if.i_data1_l = 8'(l);
        corr_if.i_data1_r = 8'(r);
        corr_if.i_data1_u = 8'(u);
        corr_if.i_data1_d = 8'(d);
        corr_if.i_depth0  = 16'(dp0);
        corr_if.i_depth1  = 16'(dp1);
    endtask

    // After send returns, o_valid/o_residual reflect that correspondence
    task automatic send(input int d0, input int c, input int dp0, input int dp1);
        drive(d0, c, 0, 0, 0, 0, dp0, dp1);
        tick();
        corr_if.i_valid = 1'b0;
        tick();
    endtask

    task automatic start_frame();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic end_frame(input string tag, input int exp_cnt, input longint exp_sse);
        i_frame_end = 1'b1;
        tick();
        i_frame_end = 1'b0;
        tick();
        tick();
        chk({tag, "_stat_early"}, o_stat_valid, 0);
        tick();
        chk({tag, "_stat_pulse"}, o_stat_valid, 1);
        chk({tag, "_cnt"}, o_corr_cnt, exp_cnt);
        chk({tag, "_sse"}, o_sse, exp_sse);
        tick();
        chk({tag, "_stat_drop"}, o_stat_valid, 0);
        chk({tag, "_cnt_hold"}, o_corr_cnt, exp_cnt);
    endtask

    initial begin
        rst_n         = 1'b0;
        i_frame_start = 1'b0;
        i_frame_end   = 1'b0;
        r_min_depth   = 16'd500;
        r_max_depth   = 16'd5000;
        r_max_res     = 8'd50;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        corr_if.i_valid = 1'b0;
        tick();
        tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_residual", o_residual, 0);
        chk("rst_stat", o_stat_valid, 0);
        chk("rst_cnt", o_corr_cnt, 0);
        chk("rst_sse", o_sse, 0);
        rst_n = 1'b1;
        tick();

        // Single correspondence outside any frame
        drive(100, 120, 90, 110, 80, 140, 1000, 900);
        tick();
        corr_if.i_valid = 1'b0;
        chk("lat1_valid", o_valid, 0);
        tick();
        chk("single_valid", o_valid, 1);
        chk("single_res", o_residual, 20);
        chk("single_gx", o_grad_x, 20);
        chk("single_gy", o_grad_y, 60);
        tick();
        chk("single_drop", o_valid, 0);

        // Three correspondences back to back in a frame
        start_frame();
        drive(100, 120, 0, 0, 0, 0, 1000, 900);
        tick();
        drive(100, 90, 0, 0, 0, 0, 1000, 900);
        tick();
        drive(100, 105, 0, 0, 0, 0, 1000, 900);
        tick();
        corr_if.i_valid = 1'b0;
        chk("neg_res", o_residual, -10);
        end_frame("frame3", 3, 525);

        // Depth window and zero frame-1 depth
        start_frame();
        send(100, 110, 499, 900);
        chk("depth_below", o_valid, 0);
        send(100, 110, 5001, 900);
        chk("depth_above", o_valid, 0);
        send(100, 110, 1000, 0);
        chk("depth1_zero", o_valid, 0);
        send(100, 110, 500, 900);
        chk("depth_min_edge", o_valid, 1);
        send(100, 110, 5000, 900);
        chk("depth_max_edge", o_valid, 1);
        end_frame("depth", 2, 200);

        // Residual limit edges
        start_frame();
        send(100, 150, 1000, 900);
        chk("res_p50", o_valid, 1);
        send(100, 50, 1000, 900);
        chk("res_m50", o_valid, 1);
        send(100, 151, 1000, 900);
        chk("res_p51", o_valid, 0);
        chk("res_hold", o_residual, -50);
        end_frame("reslim", 2, 5000);

        r_max_res = 8'd0;
        send(77, 77, 1000, 900);
        chk("max0_exact", o_valid, 1);
        send(77, 78, 1000, 900);
        chk("max0_plus1", o_valid, 0);
        send(77, 76, 1000, 900);
        chk("max0_minus1", o_valid, 0);

        // Saturation on the narrow instance, exact sums on the wide one
        r_max_res = 8'd255;
        start_frame();
        for (int i = 0; i < 10; i++) begin
            drive(0, 255, 0, 0, 0, 0, 1000, 900);
            tick();
        end
        corr_if.i_valid = 1'b0;
        end_frame("sat_wide", 10, 650250);
        chk("sat_cnt", s_corr_cnt, 7);
        chk("sat_sse", s_sse, 131071);

        // Abort mid-frame, then a short frame
        r_max_res = 8'd50;
        start_frame();
        for (int i = 0; i < 5; i++) begin
            drive(100, 110, 0, 0, 0, 0, 1000, 900);
            tick();
        end
        corr_if.i_valid = 1'b0;
        tick();
        tick();
        start_frame();
        chk("abort_nopulse", o_stat_valid, 0);
        send(100, 110, 1000, 900);
        send(100, 110, 1000, 900);
        end_frame("abort", 2, 200);

        // Reset while flushing
        start_frame();
        send(100, 130, 1000, 900);
        i_frame_end = 1'b1;
        tick();
        i_frame_end = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_flush_valid", o_valid, 0);
        chk("rst_flush_res", o_residual, 0);
        chk("rst_flush_cnt", o_corr_cnt, 0);
        chk("rst_flush_sse", o_sse, 0);
        chk("rst_flush_stat", o_stat_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_flush_nopulse", o_stat_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
